// File: rtl/inst_mem_resp_if.sv
// rtl/inst_mem_resp_if.sv - fetch and load-port bundle for the instruction-memory responder
//
// Purpose: groups the fetch handshake (request, response, busy) and the program
// store load port into one interface.
//   master : core / testbench side, drives inst_ena, inst_addr and the load port
//   slave  : responder side, drives busy, inst_valid, inst, inst_err
// Signals:
//   inst_ena   fetch request strobe
//   inst_addr  64-bit fetch byte address
//   busy       request in flight, inst_ena ignored
//   inst_valid one-cycle response strobe
//   inst       fetched instruction, held until next response
//   inst_err   access fault, qualified by inst_valid
//   load_ena   store write strobe
//   load_addr  store word index
//   load_data  store write data

interface inst_mem_resp_if #(
  parameter int unsigned DEPTH_LOG2 = 10
);
  logic                  inst_ena;
  logic [63:0]           inst_addr;
  logic                  busy;
  logic                  inst_valid;
  logic [31:0]           inst;
  logic                  inst_err;
  logic                  load_ena;
  logic [DEPTH_LOG2-1:0] load_addr;
  logic [31:0]           load_data;

  modport master (
    output inst_ena, inst_addr, load_ena, load_addr, load_data,
    input  busy, inst_valid, inst, inst_err
  );

  modport slave (
    input  inst_ena, inst_addr, load_ena, load_addr, load_data,
    output busy, inst_valid, inst, inst_err
  );
endinterface

// File: rtl/inst_mem_resp.sv
// rtl/inst_mem_resp.sv - instruction-memory responder with programmable wait states
//
// Purpose: word-addressed program store answering one fetch at a time. A fetch
// accepted while not busy returns its instruction WAIT_CYCLES edges after the
// accept edge, with inst_valid pulsing for one cycle. Misaligned, below-base and
// beyond-store addresses answer with inst_err=1 and a NOP. The load port writes
// the store in any cycle; a read and write of the same word on the same edge
// returns the old word.
// Optional feature: define INST_MEM_PREFETCH_EN to add a one-entry next-word
// buffer; a fetch that hits it answers on the accept edge itself.
// Ports:
//   clk  core clock, rising edge
//   rst  asynchronous active-low reset (store contents are kept)
//   bus  inst_mem_resp_if.slave, fetch handshake and load port

module inst_mem_resp #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic           clk,
  input  logic           rst,
  inst_mem_resp_if.slave bus
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  busy_q;
  logic                  valid_q;
  logic [31:0]           inst_q;
  logic                  err_q;
  logic [63:0]           addr_q;

  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic [63:0]           resp_addr;
  logic [63:0]           byte_off;
  logic [63:0]           word_off;
  logic                  fault;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           rd_word;
  logic [31:0]           resp_word;
  logic                  pf_hit;
  logic                  enter_resp;

  assign bus.busy       = busy_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_err   = err_q;

  // Store write port; the read below sees the pre-write contents on the same edge.
  always_ff @(posedge clk) begin
    if (bus.load_ena) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  assign accept = bus.inst_ena & ~busy_q;

  // Outside WAIT the address being answered is the one on the bus this cycle
  // (zero-wait or buffer-hit fetch); inside WAIT it is the latched one.
  assign resp_addr = (state_q == S_WAIT) ? addr_q : bus.inst_addr;

  always_comb begin
    byte_off = resp_addr - BASE_ADDR;
    word_off = byte_off >> 2;
    fault    = (resp_addr[1:0] != 2'b00) || (resp_addr < BASE_ADDR) || (word_off >= 64'(DEPTH));
    idx      = word_off[DEPTH_LOG2-1:0];
    rd_word  = mem[idx];
  end

`ifdef INST_MEM_PREFETCH_EN
  logic [DEPTH_LOG2-1:0] pf_tag;
  logic [31:0]           pf_data;
  logic                  pf_valid;
  logic [DEPTH_LOG2:0]   nxt_idx;

  assign nxt_idx   = {1'b0, idx} + (DEPTH_LOG2 + 1)'(1);
  assign pf_hit    = accept & ~fault & pf_valid & (idx == pf_tag);
  assign resp_word = pf_hit ? pf_data : rd_word;

  // Refill with the following word on every good response; any store write to
  // the tagged word (including one landing on the refill edge) kills the entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pf_valid <= 1'b0;
      pf_tag   <= '0;
      pf_data  <= '0;
    end else if (enter_resp && !fault) begin
      pf_tag   <= nxt_idx[DEPTH_LOG2-1:0];
      pf_data  <= mem[nxt_idx[DEPTH_LOG2-1:0]];
      pf_valid <= ~nxt_idx[DEPTH_LOG2] &
                  ~(bus.load_ena && (bus.load_addr == nxt_idx[DEPTH_LOG2-1:0]));
    end else if (bus.load_ena && (bus.load_addr == pf_tag)) begin
      pf_valid <= 1'b0;
    end
  end
`else
  assign pf_hit    = 1'b0;
  assign resp_word = rd_word;
`endif

  assign enter_resp = (accept && (pf_hit || (WAIT_CYCLES == 0))) ||
                      ((state_q == S_WAIT) && (cnt_q == 4'd0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      inst_q  <= NOP;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_RESP: begin
          if (accept) begin
            addr_q <= bus.inst_addr;
            if (enter_resp) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (enter_resp) begin
        valid_q <= 1'b1;
        err_q   <= fault;
        inst_q  <= fault ? NOP : resp_word;
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_resp.sv
// tb/tb_inst_mem_resp.sv - self-checking bench for inst_mem_resp

module tb_inst_mem_resp;

  localparam int          DEPTH_LOG2  = 10;
  localparam int          DEPTH       = 1 << DEPTH_LOG2;
  localparam int          WAIT_CYCLES = 2;
  localparam logic [63:0] BASE        = 64'h8000_0000;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  inst_mem_resp_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  inst_mem_resp #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WAIT_CYCLES(WAIT_CYCLES),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: store image plus a single outstanding fetch scheduled in edge numbers.
  logic [31:0] mmem [DEPTH];
  int          edge_n    = 0;
  int          free_edge = 0;
  int          resp_edge = 0;
  bit          pend      = 0;
  logic [63:0] pend_addr = '0;
  bit          acc_flag  = 0;
  bit          exp_valid = 0;
  bit          exp_busy  = 0;
  bit          exp_err   = 0;
  logic [31:0] exp_inst  = NOP;
`ifdef INST_MEM_PREFETCH_EN
  bit          pf_v   = 0;
  int          pf_tag = 0;
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void decode(input logic [63:0] a, output bit f, output int idx);
    logic [63:0] w;
    f   = 0;
    idx = 0;
    if (a < BASE || (a % 4) != 0) begin
      f = 1;
    end else begin
      w = (a - BASE) / 4;
      if (w >= 64'(DEPTH)) f = 1;
      else idx = int'(w);
    end
  endfunction

  task automatic model_edge();
    bit          f;
    int          idx;
    bit          hit;
    logic [63:0] a;
    edge_n++;
    exp_valid = 0;
    acc_flag  = 0;
    a         = bus.inst_addr;
    if (bus.inst_ena && edge_n >= free_edge) begin
      acc_flag = 1;
      hit      = 0;
`ifdef INST_MEM_PREFETCH_EN
      decode(a, f, idx);
      hit = !f && pf_v && (idx == pf_tag);
`endif
      pend      = 1;
      pend_addr = a;
      resp_edge = edge_n + (hit ? 0 : WAIT_CYCLES);
      free_edge = resp_edge + 1;
    end
    if (pend && resp_edge == edge_n) begin
      decode(pend_addr, f, idx);
      exp_valid = 1;
      exp_err   = f;
      exp_inst  = f ? NOP : mmem[idx];
      pend      = 0;
`ifdef INST_MEM_PREFETCH_EN
      if (!f) begin
        pf_tag = idx + 1;
        pf_v   = (idx + 1 < DEPTH);
      end
`endif
    end
    exp_busy = pend;
    if (bus.load_ena) begin
      mmem[bus.load_addr] = bus.load_data;
`ifdef INST_MEM_PREFETCH_EN
      if (pf_tag == int'(bus.load_addr)) pf_v = 0;
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    if (rst) begin
      check_eq("valid", bus.inst_valid, exp_valid);
      check_eq("busy", bus.busy, exp_busy);
      check_eq("inst", bus.inst, exp_inst);
      check_eq("err", bus.inst_err, exp_err);
    end
  endtask

  // Asserts reset between edges, checks the asynchronous clear, holds two edges, releases.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check_eq("rst_busy", bus.busy, 64'd0);
    check_eq("rst_valid", bus.inst_valid, 64'd0);
    check_eq("rst_inst", bus.inst, 64'(NOP));
    check_eq("rst_err", bus.inst_err, 64'd0);
    pend      = 0;
    exp_valid = 0;
    exp_busy  = 0;
    exp_inst  = NOP;
    exp_err   = 0;
    free_edge = 0;
`ifdef INST_MEM_PREFETCH_EN
    pf_v = 0;
`endif
    bus.inst_ena = 1'b0;
    bus.load_ena = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
  endtask

  task automatic fetch(input logic [63:0] a);
    bus.inst_ena  = 1'b1;
    bus.inst_addr = a;
    step();
    bus.inst_ena = 1'b0;
    repeat (WAIT_CYCLES) step();
  endtask

  logic [63:0] fault_addrs [4];
  bit          fault_exp   [4];
  logic [63:0] cur_addr;
  logic [63:0] last_addr;
  logic [63:0] t;
  int          vcount;
  int          sel;

  initial begin
    bus.inst_ena  = 1'b0;
    bus.inst_addr = '0;
    bus.load_ena  = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("init_busy", bus.busy, 64'd0);
    check_eq("init_valid", bus.inst_valid, 64'd0);
    check_eq("init_inst", bus.inst, 64'(NOP));
    #2 rst = 1'b1;

    // Preload the whole store through the load port.
    for (int i = 0; i < DEPTH; i++) begin
      bus.load_ena  = 1'b1;
      bus.load_addr = DEPTH_LOG2'(i);
      bus.load_data = (i == 0) ? 32'h0010_0093 : (i == 5) ? 32'hAAAA_AAAA : $urandom;
      step();
    end
    bus.load_ena = 1'b0;

    // Reset in the middle of a wait: immediate clear, no late pulse.
    bus.inst_ena  = 1'b1;
    bus.inst_addr = BASE + 64'h20;
    step();
    bus.inst_ena = 1'b0;
    step();
    do_reset();
    repeat (4) step();

    // Basic fetch latency and data.
    bus.inst_ena  = 1'b1;
    bus.inst_addr = BASE;
    step();
    bus.inst_ena = 1'b0;
    check_eq("t2_busy1", bus.busy, 64'd1);
    step();
    check_eq("t2_busy2", bus.busy, 64'd1);
    check_eq("t2_novalid", bus.inst_valid, 64'd0);
    step();
    check_eq("t2_valid", bus.inst_valid, 64'd1);
    check_eq("t2_inst", bus.inst, 64'h0010_0093);
    check_eq("t2_err", bus.inst_err, 64'd0);
    step();

    // Faults and the last in-range word.
    fault_addrs[0] = 64'h8000_0002; fault_exp[0] = 1;
    fault_addrs[1] = 64'h7FFF_FFFC; fault_exp[1] = 1;
    fault_addrs[2] = 64'h8000_1000; fault_exp[2] = 1;
    fault_addrs[3] = 64'h8000_0FFC; fault_exp[3] = 0;
    for (int k = 0; k < 4; k++) begin
      fetch(fault_addrs[k]);
      check_eq("t3_err", bus.inst_err, 64'(fault_exp[k]));
      if (fault_exp[k]) check_eq("t3_nop", bus.inst, 64'(NOP));
      step();
    end

    // Continuous requests, address advancing on each accept.
    cur_addr = BASE + 64'h40;
    vcount   = 0;
    bus.inst_ena = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bus.inst_addr = cur_addr;
      step();
      if (bus.inst_valid) vcount++;
      if (acc_flag) cur_addr = cur_addr + 64'd4;
    end
    bus.inst_ena = 1'b0;
`ifndef INST_MEM_PREFETCH_EN
    check_eq("t4_pulses", 64'(vcount), 64'd10);
`endif
    repeat (3) step();

    // Same-edge write and read of word 5.
    bus.inst_ena  = 1'b1;
    bus.inst_addr = BASE + 64'h14;
    step();
    bus.inst_ena = 1'b0;
    step();
    bus.load_ena  = 1'b1;
    bus.load_addr = DEPTH_LOG2'(5);
    bus.load_data = 32'h5555_5555;
    step();
    bus.load_ena = 1'b0;
    check_eq("t5_old", bus.inst, 64'hAAAA_AAAA);
    step();
    fetch(BASE + 64'h14);
    check_eq("t5_new", bus.inst, 64'h5555_5555);
    step();

`ifdef INST_MEM_PREFETCH_EN
    fetch(BASE);
    bus.inst_ena  = 1'b1;
    bus.inst_addr = BASE + 64'h4;
    step();
    bus.inst_ena = 1'b0;
    check_eq("t6_hit_valid", bus.inst_valid, 64'd1);
    step();
    fetch(BASE);
    bus.load_ena  = 1'b1;
    bus.load_addr = DEPTH_LOG2'(1);
    bus.load_data = 32'h1234_5678;
    step();
    bus.load_ena  = 1'b0;
    bus.inst_ena  = 1'b1;
    bus.inst_addr = BASE + 64'h4;
    step();
    bus.inst_ena = 1'b0;
    check_eq("t6_miss_valid", bus.inst_valid, 64'd0);
    step();
    step();
    check_eq("t6_valid", bus.inst_valid, 64'd1);
    check_eq("t6_inst", bus.inst, 64'h1234_5678);
    step();
`endif

    // Randomized traffic.
    last_addr = BASE;
    for (int c = 0; c < 2000; c++) begin
      bus.inst_ena = ($urandom_range(0, 99) < 60);
      sel = $urandom_range(0, 9);
      case (sel)
        0:       bus.inst_addr = BASE + 64'(4 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(1, 3));
        1:       bus.inst_addr = BASE - 64'(4 * $urandom_range(1, 16));
        2:       bus.inst_addr = BASE + 64'(4 * DEPTH) + 64'(4 * $urandom_range(0, 16));
        3, 4, 5: bus.inst_addr = last_addr + 64'd4;
        default: bus.inst_addr = BASE + 64'(4 * $urandom_range(0, DEPTH - 1));
      endcase
      bus.load_ena = ($urandom_range(0, 4) == 0);
      t = ((last_addr - BASE) >> 2) + 64'd1;
      bus.load_addr = $urandom_range(0, 1) ? t[DEPTH_LOG2-1:0] : DEPTH_LOG2'($urandom_range(0, DEPTH - 1));
      bus.load_data = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step();
        if (acc_flag) last_addr = bus.inst_addr;
      end
    end
    bus.inst_ena = 1'b0;
    bus.load_ena = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
